// File: rtl/in_cond_pkg.sv
// Shared types for the input conditioner: debounce FSM state encoding and counter width.
package in_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/in_conditioner_if.sv
// Signal bundle between a pin source and the input conditioner.
// GLITCH_CNT exists only when IN_COND_GLITCH_CNT_EN is defined.
interface in_conditioner_if;
    import in_cond_pkg::*;

    logic             RAW_IN;
    logic             OUT;
    logic             RISE;
    logic             FALL;
`ifdef IN_COND_GLITCH_CNT_EN
    logic [CNT_W-1:0] GLITCH_CNT;
`endif

    modport master (
        output RAW_IN,
        input  OUT,
        input  RISE,
        input  FALL
`ifdef IN_COND_GLITCH_CNT_EN
        , input GLITCH_CNT
`endif
    );

    modport slave (
        input  RAW_IN,
        output OUT,
        output RISE,
        output FALL
`ifdef IN_COND_GLITCH_CNT_EN
        , output GLITCH_CNT
`endif
    );

endinterface

// File: rtl/in_conditioner_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit level; resets to 0.
module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/in_conditioner.sv
// Synchronise and debounce a raw pin level; emits registered OUT plus RISE/FALL pulses.
// Define IN_COND_GLITCH_CNT_EN to add the saturating rejected-transition counter GLITCH_CNT.
module in_conditioner
    import in_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RST,
    in_conditioner_if.slave    io
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (io.RAW_IN),
        .q     (sync_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (sync_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign io.OUT  = out_q;
    assign io.RISE = rise_q;
    assign io.FALL = fall_q;

`ifdef IN_COND_GLITCH_CNT_EN
    logic             glitch_evt;
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // A glitch is a WAIT state falling back to its originating stable state.
    always_comb begin
        glitch_evt   = ((state_q == WAIT_HI) && !sync_q) ||
                       ((state_q == WAIT_LO) &&  sync_q);
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_evt && (glitch_cnt_q != '1)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign io.GLITCH_CNT = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_in_conditioner.sv
// Self-checking bench for in_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// GLITCH_CNT checks are active when IN_COND_GLITCH_CNT_EN is defined.
module tb_in_conditioner;

    localparam int LATENCY = 6;

    typedef struct {
        bit is_rise;
        int edge_no;
    } ev_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    int   exp_glitch;
    ev_t  sb[$];

    in_conditioner_if dut_if ();

    in_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .io  (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if ((dut_if.RISE & dut_if.FALL) !== 1'b0) begin
                n_fail++;
                $display("FAIL rise_fall_exclusive: RISE=%b FALL=%b, required not both high at edge %0d",
                         dut_if.RISE, dut_if.FALL, edge_cnt);
            end
        end
    end

    // Waits for the first RISE/FALL pulse, bounded by budget cycles.
    task automatic wait_pulse(input int budget, output bit seen, output bit is_rise, output int at_edge);
        seen    = 1'b0;
        is_rise = 1'b0;
        at_edge = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dut_if.RISE === 1'b1 || dut_if.FALL === 1'b1) begin
                seen    = 1'b1;
                is_rise = dut_if.RISE;
                at_edge = edge_cnt;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        dut_if.RAW_IN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: OUT/RISE/FALL=%b, required 000", {dut_if.OUT, dut_if.RISE, dut_if.FALL});
        end
`ifdef IN_COND_GLITCH_CNT_EN
        n_checks++;
        if (dut_if.GLITCH_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_glitch_cnt: got %0d, required 0", dut_if.GLITCH_CNT);
        end
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_low cycle %0d: OUT/RISE/FALL=%b, required 000", i, {dut_if.OUT, dut_if.RISE, dut_if.FALL});
            end
        end
    endtask

    task automatic test_edge(input bit rising);
        bit  seen, is_rise;
        int  at_edge;
        ev_t exp;
        @(negedge clk);
        dut_if.RAW_IN = rising;
        sb.push_back('{is_rise: rising, edge_no: edge_cnt + LATENCY});
        wait_pulse(20, seen, is_rise, at_edge);
        exp = sb.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL edge_timeout: no pulse seen, required %s at edge %0d", rising ? "RISE" : "FALL", exp.edge_no);
        end else begin
            n_checks++;
            if (is_rise !== exp.is_rise) begin
                n_fail++;
                $display("FAIL edge_kind: got rise=%b, required rise=%b", is_rise, exp.is_rise);
            end
            n_checks++;
            if (at_edge !== exp.edge_no) begin
                n_fail++;
                $display("FAIL edge_latency: pulse at edge %0d, required edge %0d", at_edge, exp.edge_no);
            end
        end
        n_checks++;
        if (dut_if.OUT !== rising) begin
            n_fail++;
            $display("FAIL edge_out: OUT=%b, required %b", dut_if.OUT, rising);
        end
        @(negedge clk);
        n_checks++;
        if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== {rising, 2'b00}) begin
            n_fail++;
            $display("FAIL edge_one_cycle: OUT/RISE/FALL=%b, required %b", {dut_if.OUT, dut_if.RISE, dut_if.FALL}, {rising, 2'b00});
        end
    endtask

    // Holds RAW_IN at the opposite level for one cycle short of acceptance.
    task automatic test_glitch(input bit level);
        bit seen, is_rise;
        int at_edge;
        @(negedge clk);
        dut_if.RAW_IN = ~level;
        repeat (3) @(negedge clk);
        dut_if.RAW_IN = level;
        if (exp_glitch < 255) exp_glitch++;
        wait_pulse(12, seen, is_rise, at_edge);
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL glitch_no_pulse: pulse rise=%b at edge %0d, required none", is_rise, at_edge);
        end
        n_checks++;
        if (dut_if.OUT !== level) begin
            n_fail++;
            $display("FAIL glitch_out: OUT=%b, required %b", dut_if.OUT, level);
        end
`ifdef IN_COND_GLITCH_CNT_EN
        n_checks++;
        if (dut_if.GLITCH_CNT !== 8'(exp_glitch)) begin
            n_fail++;
            $display("FAIL glitch_cnt: got %0d, required %0d", dut_if.GLITCH_CNT, exp_glitch);
        end
`endif
    endtask

    task automatic test_reset_abort();
        bit  seen, is_rise;
        int  at_edge;
        ev_t exp;
        @(negedge clk);
        dut_if.RAW_IN = 1'b1;
        repeat (5) @(negedge clk);
        rst_n      = 1'b0;
        exp_glitch = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_in_reset %0d: OUT/RISE/FALL=%b, required 000", i, {dut_if.OUT, dut_if.RISE, dut_if.FALL});
            end
            @(negedge clk);
        end
`ifdef IN_COND_GLITCH_CNT_EN
        n_checks++;
        if (dut_if.GLITCH_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_glitch_cnt: got %0d, required 0", dut_if.GLITCH_CNT);
        end
`endif
        rst_n = 1'b1;
        sb.push_back('{is_rise: 1'b1, edge_no: edge_cnt + LATENCY});
        wait_pulse(20, seen, is_rise, at_edge);
        exp = sb.pop_front();
        n_checks++;
        if (!seen || is_rise !== 1'b1 || at_edge !== exp.edge_no) begin
            n_fail++;
            $display("FAIL abort_release_rise: seen=%b rise=%b edge=%0d, required RISE at edge %0d",
                     seen, is_rise, at_edge, exp.edge_no);
        end
        n_checks++;
        if (dut_if.OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release_out: OUT=%b, required 1", dut_if.OUT);
        end
    endtask

    task automatic test_glitch_saturation();
        bit noisy;
        noisy = 1'b0;
        for (int p = 0; p < 300; p++) begin
            dut_if.RAW_IN = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (c == 2) dut_if.RAW_IN = 1'b0;
                @(negedge clk);
                if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== 3'b000) noisy = 1'b1;
            end
            if (exp_glitch < 255) exp_glitch++;
        end
        repeat (8) begin
            @(negedge clk);
            if ({dut_if.OUT, dut_if.RISE, dut_if.FALL} !== 3'b000) noisy = 1'b1;
        end
        n_checks++;
        if (noisy) begin
            n_fail++;
            $display("FAIL saturation_quiet: OUT/RISE/FALL activity seen, required none");
        end
`ifdef IN_COND_GLITCH_CNT_EN
        n_checks++;
        if (dut_if.GLITCH_CNT !== 8'(exp_glitch)) begin
            n_fail++;
            $display("FAIL saturation_cnt: got %0d, required %0d", dut_if.GLITCH_CNT, exp_glitch);
        end
`endif
    endtask

    initial begin
        edge_cnt   = 0;
        n_checks   = 0;
        n_fail     = 0;
        exp_glitch = 0;
        test_reset();
        test_glitch(1'b0);
        test_edge(1'b1);
        test_glitch(1'b1);
        test_edge(1'b0);
        test_reset_abort();
        test_edge(1'b0);
        test_glitch_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/in_conditioner.md
IN_CONDITIONER -- requirements
Module: in_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on RAW_IN; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples needed to accept a level change; legal range 2..255.
REQ-003 CLK  input  1  single clock; all state on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 RAW_IN  input  1  asynchronous raw level from the pin.
REQ-006 OUT  output  1  debounced level, registered; drives the downstream IN of TOP.
REQ-007 RISE  output  1  one-cycle pulse when OUT goes 0->1.
REQ-008 FALL  output  1  one-cycle pulse when OUT goes 1->0.
REQ-009 GLITCH_CNT  output  8  rejected-transition count; present only with IN_COND_GLITCH_CNT_EN.

Function
REQ-010 RAW_IN shall pass through SYNC_STAGES flops; the last flop output is sync_q, the only signal the FSM reads.
REQ-011 FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO: sync_q=1 -> WAIT_HI, cnt=1; else stay, cnt=0.
REQ-013 WAIT_HI: sync_q=0 -> STABLE_LO, cnt=0, glitch event; sync_q=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HI, OUT=1, RISE=1; else cnt+1.
REQ-014 STABLE_HI/WAIT_LO shall mirror REQ-012/013 with polarity inverted, asserting FALL and OUT=0 on acceptance.
REQ-015 OUT shall change on the edge at which sync_q has been sampled at the new level on DEBOUNCE_CYCLES consecutive edges; total latency from first edge sampling new RAW_IN level = SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-016 RISE and FALL shall be registered, high for exactly one cycle, never simultaneously high.
REQ-017 A pulse on sync_q shorter than DEBOUNCE_CYCLES samples shall leave OUT, RISE, FALL unchanged.
REQ-018 cnt width shall be 8 bits; cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
REQ-019 OUT shall equal 1 exactly in STABLE_HI and WAIT_LO.

Reset
REQ-020 RST low shall asynchronously force: sync flops 0, state STABLE_LO, cnt 0, OUT 0, RISE 0, FALL 0, GLITCH_CNT 0.
REQ-021 Reset asserted mid-WAIT_HI or mid-WAIT_LO shall abort the pending change with no RISE/FALL emitted.
REQ-022 After RST deasserts with RAW_IN=1, OUT shall rise after SYNC_STAGES+DEBOUNCE_CYCLES edges, with RISE pulse.

Configuration
REQ-023 Macro IN_COND_GLITCH_CNT_EN defined: GLITCH_CNT port exists, increments by 1 on each WAIT_HI->STABLE_LO or WAIT_LO->STABLE_HI transition, saturates at 255.
REQ-024 Macro undefined: GLITCH_CNT port and counter absent; all other behaviour identical.

Structure
REQ-025 Package in_cond_pkg shall hold the 2-bit state typedef (four states) and the counter width constant 8.
REQ-026 Sub-module sync_ff (parameterised depth, async active-low reset to 0) shall implement REQ-010; FSM, counters and pulses live in in_conditioner.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-027 Reset, RAW_IN=0 held -> OUT=0, RISE=FALL=0 for 20 cycles.
REQ-028 RAW_IN 0->1 held -> OUT=1 on 6th edge after first sample of 1; RISE high that single cycle.
REQ-029 RAW_IN high for 3 cycles then low -> OUT stays 0, no RISE; GLITCH_CNT=1 when macro defined.
REQ-030 OUT=1, RAW_IN 1->0 held -> OUT=0 after 6 edges, FALL one cycle.
REQ-031 RAW_IN rises, RST pulsed low on 3rd edge in WAIT_HI -> OUT=0, no RISE; after release with RAW_IN=1, RISE 6 edges later.
REQ-032 300 short (2-cycle) RAW_IN pulses with macro -> GLITCH_CNT saturates at 255, OUT remains 0.
